// File: rtl/uart_pkg.sv
// Shared definitions for the UART TX arbiter: FSM state encoding, frame width
// and the default watchdog limit.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LAUNCH    = 2'd1,
    WAIT_DONE = 2'd2,
    RELEASE   = 2'd3
  } arb_state_t;

  localparam int UART_FRAME_W       = 128;
  localparam int TIMEOUT_CYCLES_DEF = 1048576;
  localparam int WDOG_W             = 21;

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Bundle of requester-side and transceiver-side signals around the TX arbiter.
// master = arbiter view, slave = requesters plus transceiver view.
interface uart_tx_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 128
);
  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        gnt;
  logic [NUM_REQ-1:0]        done;
  logic                      busy;
  logic [DATA_W-1:0]         tx_data;
  logic                      tx_wr;
  logic                      tx_done;
  logic                      err;

  modport master (
    input  req, req_data, tx_done,
    output gnt, done, busy, tx_data, tx_wr, err
  );

  modport slave (
    output req, req_data, tx_done,
    input  gnt, done, busy, tx_data, tx_wr, err
  );
endinterface

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin priority encoder: first set request at or above
// rr_ptr, wrapping modulo NUM_REQ.
module rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   rr_ptr,
  output logic [IDX_W-1:0]   win,
  output logic               any_req
);

  always_comb begin
    // NOTE: every output gets a default before the search so no latch is inferred.
    win     = '0;
    any_req = 1'b0;
    // Walk offsets from farthest to nearest so the nearest hit is written last.
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      automatic int j = int'(rr_ptr) + i;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      if (req[j]) begin
        win     = IDX_W'(j);
        any_req = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transceiver TX path among NUM_REQ requesters.
// Optional watchdog on the transceiver handshake: define UART_TX_TIMEOUT_EN.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int DATA_W         = UART_FRAME_W,
  parameter int IDX_W          = $clog2(NUM_REQ),
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic                sys_clk,
  input  logic                sys_rst_n,
  uart_tx_arbiter_if.master   bus
);

  if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 2) begin : g_bad_cfg
    $error("uart_tx_arbiter: NUM_REQ must be 2..8 and TIMEOUT_CYCLES >= 2");
  end

  arb_state_t          state_q, state_d;
  logic [IDX_W-1:0]    rr_ptr_q;
  logic [IDX_W-1:0]    win_q;
  logic [IDX_W-1:0]    win;
  logic                any_req;
  logic [DATA_W-1:0]   tx_data_q;
  logic                timeout;
  logic                timed_out_q;
  logic                capture;
  logic                finish;

  logic [NUM_REQ-1:0]  gnt;
  logic [NUM_REQ-1:0]  done;
  logic                busy;
  logic                tx_wr;
  logic                err;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_pick (
    .req     (bus.req),
    .rr_ptr  (rr_ptr_q),
    .win     (win),
    .any_req (any_req)
  );

  assign capture = (state_q == IDLE) && any_req;
  assign finish  = (state_q == WAIT_DONE) && (bus.tx_done || timeout);

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so all registers see pre-edge values.
    if (!sys_rst_n) state_q <= IDLE;
    else            state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:      if (any_req) state_d = LAUNCH;
      LAUNCH:    state_d = WAIT_DONE;
      WAIT_DONE: if (bus.tx_done || timeout) state_d = RELEASE;
      RELEASE:   state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  // Frame and winner are captured only on the grant edge, so requesters may
  // rewrite req_data while the transceiver is still shifting the old frame.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      win_q     <= '0;
      rr_ptr_q  <= '0;
      tx_data_q <= '0;
    end else begin
      if (capture) begin
        win_q     <= win;
        tx_data_q <= bus.req_data[int'(win)*DATA_W +: DATA_W];
      end
      if (finish) begin
        rr_ptr_q <= (win_q == IDX_W'(NUM_REQ - 1)) ? '0 : win_q + IDX_W'(1);
      end
    end
  end

`ifdef UART_TX_TIMEOUT_EN
  localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(TIMEOUT_CYCLES - 1);

  logic [WDOG_W-1:0] wdog_q;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      wdog_q      <= '0;
      timed_out_q <= 1'b0;
    end else begin
      if (state_q == LAUNCH)         wdog_q <= '0;
      else if (state_q == WAIT_DONE) wdog_q <= wdog_q + WDOG_W'(1);
      // A tx_done arriving on the expiry cycle wins over the timeout.
      if (finish) timed_out_q <= ~bus.tx_done;
    end
  end

  assign timeout = (state_q == WAIT_DONE) && (wdog_q == WDOG_LAST);
`else
  assign timeout     = 1'b0;
  assign timed_out_q = 1'b0;
`endif

  always_comb begin
    gnt   = '0;
    done  = '0;
    busy  = 1'b0;
    tx_wr = 1'b0;
    err   = 1'b0;
    unique case (state_q)
      IDLE: ;
      LAUNCH: begin
        gnt   = NUM_REQ'(1) << win_q;
        busy  = 1'b1;
        tx_wr = 1'b1;
      end
      WAIT_DONE: begin
        gnt  = NUM_REQ'(1) << win_q;
        busy = 1'b1;
      end
      RELEASE: begin
        done = NUM_REQ'(1) << win_q;
        busy = 1'b1;
        err  = timed_out_q;
      end
      default: ;
    endcase
  end

  assign bus.gnt     = gnt;
  assign bus.done    = done;
  assign bus.busy    = busy;
  assign bus.tx_wr   = tx_wr;
  assign bus.err     = err;
  assign bus.tx_data = tx_data_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: transaction-level round-robin model,
// randomized frames, request patterns and transceiver latencies.
module tb_uart_tx_arbiter;

  localparam int NR = 4;
  localparam int DW = 128;

  logic sys_clk   = 1'b0;
  logic sys_rst_n = 1'b0;

  always #5 sys_clk = ~sys_clk;

  uart_tx_arbiter_if #(.NUM_REQ(NR), .DATA_W(DW)) bus ();

  uart_tx_arbiter #(
    .NUM_REQ        (NR),
    .DATA_W         (DW),
    .IDX_W          (2),
    .TIMEOUT_CYCLES (64)
  ) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .bus       (bus)
  );

  int           n_checks = 0;
  int           n_fail   = 0;
  int           m_ptr    = 0;
  logic [3:0]   req_v    = '0;
  logic [DW-1:0] frames [NR];

  // Round-robin rule: first set request at or after ptr, wrapping.
  function automatic int pick(input logic [3:0] r, input int p);
    for (int k = 0; k < NR; k++) begin
      if (r[(p + k) % NR]) return (p + k) % NR;
    end
    return -1;
  endfunction

  function automatic logic [DW-1:0] rand_frame();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic drive();
    bus.req = req_v;
    for (int i = 0; i < NR; i++) bus.req_data[i*DW +: DW] = frames[i];
  endtask

  // Entered at a negedge of an idle cycle with requests already driven;
  // returns at the negedge of the idle cycle following RELEASE.
  task automatic do_xfer(input int lat, input bit drop, input logic [3:0] raise_mask,
                         input int mut_idx, output int got_w);
    int            w;
    logic [3:0]    eg;
    logic [10:0]   obs;
    logic [DW-1:0] exp_frame;
    w = pick(req_v, m_ptr);
    got_w = -1;
    if (w < 0) begin
      n_checks++; n_fail++;
      $display("FAIL xfer_setup: got no request want a nonzero req");
      return;
    end
    eg = 4'b0001 << w;
    exp_frame = frames[w];
    @(negedge sys_clk);
    for (int i = 0; i < NR; i++) if (bus.gnt[i]) got_w = i;
    obs = {bus.gnt, bus.done, bus.busy, bus.tx_wr, bus.err};
    n_checks++;
    if (obs !== {eg, 4'b0000, 1'b1, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL launch: got gnt/done/busy/wr/err %b want %b", obs, {eg, 4'b0000, 3'b110});
    end
    n_checks++;
    if (bus.tx_data !== exp_frame) begin
      n_fail++;
      $display("FAIL launch_data: got %h want %h", bus.tx_data, exp_frame);
    end
    for (int k = 0; k <= lat; k++) begin
      if (k == 0) begin
        req_v = req_v | raise_mask;
        if (mut_idx >= 0) frames[mut_idx] = {32'hDEADBEEF, $urandom, $urandom, $urandom};
        drive();
      end
      @(negedge sys_clk);
      obs = {bus.gnt, bus.done, bus.busy, bus.tx_wr, bus.err};
      n_checks++;
      if (obs !== {eg, 4'b0000, 1'b1, 1'b0, 1'b0} || bus.tx_data !== exp_frame) begin
        n_fail++;
        $display("FAIL wait_done: got %b data %h want %b data %h", obs, bus.tx_data,
                 {eg, 4'b0000, 3'b100}, exp_frame);
      end
    end
    bus.tx_done = 1'b1;
    @(negedge sys_clk);
    bus.tx_done = 1'b0;
    obs = {bus.gnt, bus.done, bus.busy, bus.tx_wr, bus.err};
    n_checks++;
    if (obs !== {4'b0000, eg, 1'b1, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL done_pulse: got %b want %b", obs, {4'b0000, eg, 3'b100});
    end
    m_ptr = (w + 1) % NR;
    if (drop) req_v[w] = 1'b0;
    drive();
    @(negedge sys_clk);
    obs = {bus.gnt, bus.done, bus.busy, bus.tx_wr, bus.err};
    n_checks++;
    if (obs !== 11'b0) begin
      n_fail++;
      $display("FAIL release_gap: got %b want %b", obs, 11'b0);
    end
  endtask

  task automatic test_reset();
    bus.tx_done = 1'b0;
    req_v = '0;
    drive();
    sys_rst_n = 1'b0;
    #1;
    n_checks++;
    if ({bus.gnt, bus.done, bus.busy, bus.tx_wr, bus.err} !== 11'b0 || bus.tx_data !== '0) begin
      n_fail++;
      $display("FAIL reset_state: got %b data %h want 0", {bus.gnt, bus.done, bus.busy, bus.tx_wr, bus.err},
               bus.tx_data);
    end
    repeat (3) @(negedge sys_clk);
    sys_rst_n = 1'b1;
    m_ptr = 0;
    @(negedge sys_clk);
  endtask

  task automatic test_single();
    int g;
    bus.tx_done = 1'b1;
    @(negedge sys_clk);
    bus.tx_done = 1'b0;
    n_checks++;
    if ({bus.gnt, bus.done, bus.busy, bus.tx_wr, bus.err} !== 11'b0) begin
      n_fail++;
      $display("FAIL stray_tx_done: got %b want 0", {bus.gnt, bus.done, bus.busy, bus.tx_wr, bus.err});
    end
    frames[2] = 128'h00112233_44556677_8899AABB_CCDDEEFF;
    req_v = 4'b0100;
    drive();
    do_xfer(3, 1'b1, 4'b0000, -1, g);
    n_checks++;
    if (g != 2) begin
      n_fail++;
      $display("FAIL single_winner: got %0d want 2", g);
    end
  endtask

  task automatic test_all_four();
    int g;
    test_reset();
    for (int i = 0; i < NR; i++) frames[i] = rand_frame();
    req_v = 4'b1111;
    drive();
    for (int i = 0; i < NR; i++) begin
      do_xfer(i + 1, 1'b1, 4'b0000, -1, g);
      n_checks++;
      if (g != i) begin
        n_fail++;
        $display("FAIL all_four_order: got %0d want %0d", g, i);
      end
    end
  endtask

  task automatic test_fairness();
    int g;
    int exp_seq [4] = '{0, 3, 0, 3};
    test_reset();
    req_v = 4'b0001;
    drive();
    for (int i = 0; i < 4; i++) begin
      do_xfer(2, 1'b0, (i == 0) ? 4'b1000 : 4'b0000, -1, g);
      n_checks++;
      if (g != exp_seq[i]) begin
        n_fail++;
        $display("FAIL fairness_seq%0d: got %0d want %0d", i, g, exp_seq[i]);
      end
    end
    req_v = '0;
    drive();
  endtask

  task automatic test_data_stability();
    int g;
    frames[1] = rand_frame();
    req_v = 4'b0010;
    drive();
    do_xfer(5, 1'b1, 4'b0000, 1, g);
    req_v = 4'b0010;
    drive();
    do_xfer(1, 1'b1, 4'b0000, -1, g);
    n_checks++;
    if (bus.tx_data[DW-1 -: 32] !== 32'hDEADBEEF) begin
      n_fail++;
      $display("FAIL new_frame: got %h want DEADBEEF in top word", bus.tx_data[DW-1 -: 32]);
    end
  endtask

  task automatic test_reset_mid();
    int g;
    req_v = 4'b0100;
    drive();
    repeat (4) @(negedge sys_clk);
    #2 sys_rst_n = 1'b0;
    #1;
    n_checks++;
    if ({bus.gnt, bus.done, bus.busy, bus.tx_wr} !== 10'b0 || bus.tx_data !== '0) begin
      n_fail++;
      $display("FAIL async_reset: got %b data %h want 0", {bus.gnt, bus.done, bus.busy, bus.tx_wr},
               bus.tx_data);
    end
    req_v = 4'b1010;
    drive();
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    m_ptr = 0;
    do_xfer(2, 1'b1, 4'b0000, -1, g);
    n_checks++;
    if (g != 1) begin
      n_fail++;
      $display("FAIL post_reset_grant: got %0d want 1", g);
    end
    req_v = '0;
    drive();
  endtask

  task automatic test_timeout();
    int g;
    test_reset();
    frames[0] = rand_frame();
    frames[1] = rand_frame();
    req_v = 4'b0011;
    drive();
    @(negedge sys_clk);
    n_checks++;
    if (bus.tx_wr !== 1'b1 || bus.gnt !== 4'b0001) begin
      n_fail++;
      $display("FAIL stall_launch: got wr %b gnt %b want 1 0001", bus.tx_wr, bus.gnt);
    end
    for (int k = 1; k <= 64; k++) begin
      @(negedge sys_clk);
      n_checks++;
      if (bus.err !== 1'b0 || bus.done !== 4'b0 || bus.gnt !== 4'b0001) begin
        n_fail++;
        $display("FAIL stall_cycle%0d: got err %b done %b gnt %b want 0 0000 0001", k, bus.err,
                 bus.done, bus.gnt);
      end
    end
`ifdef UART_TX_TIMEOUT_EN
    @(negedge sys_clk);
`else
    repeat (36) @(negedge sys_clk);
    n_checks++;
    if (bus.err !== 1'b0 || bus.busy !== 1'b1 || bus.gnt !== 4'b0001) begin
      n_fail++;
      $display("FAIL stall_hold: got err %b busy %b gnt %b want 0 1 0001", bus.err, bus.busy, bus.gnt);
    end
    bus.tx_done = 1'b1;
    @(negedge sys_clk);
    bus.tx_done = 1'b0;
`endif
    n_checks++;
`ifdef UART_TX_TIMEOUT_EN
    if (bus.err !== 1'b1 || bus.done !== 4'b0001 || bus.gnt !== 4'b0000) begin
`else
    if (bus.err !== 1'b0 || bus.done !== 4'b0001 || bus.gnt !== 4'b0000) begin
`endif
      n_fail++;
      $display("FAIL stall_end: got err %b done %b gnt %b", bus.err, bus.done, bus.gnt);
    end
    m_ptr = 1;
    req_v[0] = 1'b0;
    drive();
    @(negedge sys_clk);
    do_xfer(1, 1'b1, 4'b0000, -1, g);
    n_checks++;
    if (g != 1) begin
      n_fail++;
      $display("FAIL after_stall_grant: got %0d want 1", g);
    end
  endtask

  task automatic test_random();
    int g;
    for (int it = 0; it < 24; it++) begin
      for (int i = 0; i < NR; i++) frames[i] = rand_frame();
      if (req_v == '0) req_v = 4'($urandom_range(1, 15));
      drive();
      do_xfer(int'($urandom_range(0, 4)), 1'b1, 4'($urandom_range(0, 15)), -1, g);
    end
    req_v = '0;
    drive();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    for (int i = 0; i < NR; i++) frames[i] = '0;
    test_reset();
    test_single();
    test_all_four();
    test_fairness();
    test_data_stability();
    test_reset_mid();
    test_random();
    test_timeout();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
